dbuf_ctrl: RTL and testbench
============================

DBUF_CTRL -- requirements
Module: dbuf_ctrl

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the tile-count and per-tile access-count fields.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset; synchronous and active-low.
REQ-004 SHALL have port config_en, input, 1 bit, config load strobe.
REQ-005 SHALL have port config_data, input, 3*COUNT_WIDTH bits, packed {NUM_TILES, WR_COUNT, RD_COUNT}, MSB first.
REQ-006 SHALL have port start, input, 1 bit, begin-run pulse.
REQ-007 SHALL have port in_vld, input, 1 bit, write-stream data valid.
REQ-008 SHALL have port in_rdy, output, 1 bit, write-stream ready.
REQ-009 SHALL have port wr_en, output, 1 bit, write-bank write strobe; wr_en = in_vld & in_rdy.
REQ-010 SHALL have port rd_stall, input, 1 bit, downstream backpressure on reads.
REQ-011 SHALL have port rd_adr_en, output, 1 bit, step strobe for the read-bank address generator.
REQ-012 SHALL have port switch_banks, output, 1 bit, one-cycle ping-pong swap pulse.
REQ-013 SHALL have port busy, output, 1 bit, high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit, one-cycle run-complete pulse.

Function
REQ-015 SHALL implement states IDLE, FILL, STEADY, DRAIN, SWAP.
REQ-016 SHALL load the three config fields only when config_en=1 in IDLE; config_en in other states is ignored.
REQ-017 SHALL, on start=1 in IDLE, enter FILL next cycle if NUM_TILES>0, else stay in IDLE and pulse done next cycle; start outside IDLE is ignored.
REQ-018 SHALL keep a write counter wr_cnt: in_rdy=1 iff state is FILL or STEADY and wr_cnt<WR_COUNT; wr_cnt increments on each wr_en.
REQ-019 SHALL keep a read counter rd_cnt: rd_adr_en=1 iff state is STEADY or DRAIN, rd_cnt<RD_COUNT, and rd_stall=0; rd_cnt increments on each rd_adr_en.
REQ-020 SHALL define write side complete as wr_cnt==WR_COUNT, read side complete as rd_cnt==RD_COUNT; a count of 0 means that side is complete on entry.
REQ-021 SHALL go FILL->SWAP in the cycle after write side completes (i.e., wr_cnt registered equal to WR_COUNT).
REQ-022 SHALL go STEADY->SWAP only when both sides are complete; whichever side finishes first idles (strobe low) until the other finishes.
REQ-023 SHALL go DRAIN->SWAP when read side completes.
REQ-024 SHALL stay in SWAP exactly one cycle with switch_banks=1; clear wr_cnt and rd_cnt; increment tiles_written if leaving FILL or STEADY; increment tiles_read if leaving STEADY or DRAIN.
REQ-025 SHALL exit SWAP using the updated tile counters: to IDLE with done=1 that same next cycle if tiles_read==NUM_TILES; else to STEADY if tiles_written<NUM_TILES; else to DRAIN.
REQ-026 SHALL size tiles_written/tiles_read at COUNT_WIDTH bits; no wrap occurs because counting stops at NUM_TILES.
REQ-027 SHALL register all outputs except wr_en and rd_adr_en, which are combinational from registered state and inputs.
REQ-028 SHALL keep in_rdy, wr_en, rd_adr_en low in IDLE and SWAP.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge (including mid-run), force IDLE; clear all counters and config registers; drive in_rdy, rd_adr_en, switch_banks, busy, done low.
REQ-030 SHALL ignore start and config_en in any cycle where rst_n=0.

Verification
REQ-031 SHALL cover NUM_TILES=3, WR=4, RD=6, in_vld=1, rd_stall=0 -> 4 switch_banks pulses, 12 wr_en, 18 rd_adr_en, one done, busy low afterwards.
REQ-032 SHALL cover NUM_TILES=1, WR=2, RD=3 -> FILL, SWAP, DRAIN, SWAP, IDLE; 2 switch_banks pulses; done at the end.
REQ-033 SHALL cover STEADY with rd_stall held high 5 cycles -> rd_adr_en low while stalled; no SWAP until rd_cnt==RD_COUNT; total rd_adr_en count unchanged.
REQ-034 SHALL cover in_vld toggling 50% in STEADY with RD=2, WR=8 -> read side idles after 2 strobes; SWAP only after the 8th wr_en.
REQ-035 SHALL cover start with NUM_TILES=0 -> busy stays 0; done pulses exactly once, next cycle.
REQ-036 SHALL cover rst_n low for one cycle mid-STEADY -> next cycle IDLE, all outputs 0; a new start after reconfig runs a full sequence correctly.

Source files
------------

// File: rtl/dbuf_ctrl.sv
// Ping-pong double-buffer sequencer: fills one bank while the other is read out,
// swapping banks once per tile until NUM_TILES tiles have been written and read.
module dbuf_ctrl #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       config_en,
    input  logic [3*COUNT_WIDTH-1:0]   config_data,
    input  logic                       start,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic                       wr_en,
    input  logic                       rd_stall,
    output logic                       rd_adr_en,
    output logic                       switch_banks,
    output logic                       busy,
    output logic                       done
);

    // state  | meaning
    // IDLE   | waiting for config / start
    // FILL   | first tile written, nothing to read yet
    // STEADY | writing tile n+1 while reading tile n
    // DRAIN  | all tiles written, reading the last one
    // SWAP   | one-cycle bank exchange
    typedef enum logic [2:0] {IDLE, FILL, STEADY, DRAIN, SWAP} state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t state, state_nxt;

    logic [COUNT_WIDTH-1:0] num_tiles, wr_count, rd_count;
    logic [COUNT_WIDTH-1:0] num_tiles_nxt, wr_count_nxt, rd_count_nxt;
    logic [COUNT_WIDTH-1:0] wr_cnt, rd_cnt, tiles_written, tiles_read;
    logic [COUNT_WIDTH-1:0] wr_cnt_nxt, rd_cnt_nxt, tiles_written_nxt, tiles_read_nxt;
    logic                   wr_side_done, rd_side_done, done_nxt;

    assign wr_side_done = (wr_cnt == wr_count);
    assign rd_side_done = (rd_cnt == rd_count);

    assign wr_en     = in_vld & in_rdy;
    assign rd_adr_en = ((state == STEADY) || (state == DRAIN)) && (rd_cnt < rd_count) && !rd_stall;

    // A config write in the same IDLE cycle as start is already honoured by that start.
    always_comb begin
        {num_tiles_nxt, wr_count_nxt, rd_count_nxt} = {num_tiles, wr_count, rd_count};
        if ((state == IDLE) && config_en) begin
            {num_tiles_nxt, wr_count_nxt, rd_count_nxt} = config_data;
        end
    end

    // Tile counters are bumped on the transition into SWAP, so SWAP itself
    // already sees the updated values when choosing its exit.
    always_comb begin
        state_nxt         = state;
        wr_cnt_nxt        = wr_cnt + COUNT_WIDTH'(wr_en);
        rd_cnt_nxt        = rd_cnt + COUNT_WIDTH'(rd_adr_en);
        tiles_written_nxt = tiles_written;
        tiles_read_nxt    = tiles_read;
        done_nxt          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    wr_cnt_nxt        = '0;
                    rd_cnt_nxt        = '0;
                    tiles_written_nxt = '0;
                    tiles_read_nxt    = '0;
                    if (num_tiles_nxt != '0) state_nxt = FILL;
                    else                     done_nxt  = 1'b1;
                end
            end
            FILL: begin
                if (wr_side_done) begin
                    state_nxt         = SWAP;
                    tiles_written_nxt = tiles_written + ONE;
                end
            end
            STEADY: begin
                if (wr_side_done && rd_side_done) begin
                    state_nxt         = SWAP;
                    tiles_written_nxt = tiles_written + ONE;
                    tiles_read_nxt    = tiles_read + ONE;
                end
            end
            DRAIN: begin
                if (rd_side_done) begin
                    state_nxt      = SWAP;
                    tiles_read_nxt = tiles_read + ONE;
                end
            end
            SWAP: begin
                wr_cnt_nxt = '0;
                rd_cnt_nxt = '0;
                if (tiles_read == num_tiles) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (tiles_written < num_tiles) begin
                    state_nxt = STEADY;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            num_tiles     <= '0;
            wr_count      <= '0;
            rd_count      <= '0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            tiles_written <= '0;
            tiles_read    <= '0;
            in_rdy        <= 1'b0;
            switch_banks  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            num_tiles     <= num_tiles_nxt;
            wr_count      <= wr_count_nxt;
            rd_count      <= rd_count_nxt;
            wr_cnt        <= wr_cnt_nxt;
            rd_cnt        <= rd_cnt_nxt;
            tiles_written <= tiles_written_nxt;
            tiles_read    <= tiles_read_nxt;
            in_rdy        <= ((state_nxt == FILL) || (state_nxt == STEADY)) && (wr_cnt_nxt < wr_count_nxt);
            switch_banks  <= (state_nxt == SWAP);
            busy          <= (state_nxt != IDLE);
            done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dbuf_ctrl.sv
// Scoreboard bench for dbuf_ctrl: each run pushes its expected strobe totals and
// busy length; a negedge monitor tallies the DUT outputs and checks them on done.
module tb_dbuf_ctrl;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic config_en = 1'b0;
    logic start = 1'b0;
    logic in_vld = 1'b0;
    logic rd_stall = 1'b0;
    logic [3*CW-1:0] config_data = '0;
    logic in_rdy, wr_en, rd_adr_en, switch_banks, busy, done;

    typedef struct {
        int sw;
        int wr;
        int rd;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int n_chk = 0;
    int n_fail = 0;
    int m_sw = 0, m_wr = 0, m_rd = 0, m_cyc = 0;

    always #5 clk = ~clk;

    dbuf_ctrl #(.COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .config_en    (config_en),
        .config_data  (config_data),
        .start        (start),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .wr_en        (wr_en),
        .rd_stall     (rd_stall),
        .rd_adr_en    (rd_adr_en),
        .switch_banks (switch_banks),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            m_sw = 0; m_wr = 0; m_rd = 0; m_cyc = 0;
        end else begin
            if (wr_en)        m_wr++;
            if (rd_adr_en)    m_rd++;
            if (switch_banks) m_sw++;
            if (busy)         m_cyc++;
            if (!busy) begin
                chk("idle_in_rdy", in_rdy, 0);
                chk("idle_rd_adr_en", rd_adr_en, 0);
            end
            if (switch_banks) begin
                chk("swap_in_rdy", in_rdy, 0);
                chk("swap_rd_adr_en", rd_adr_en, 0);
            end
            if (rd_stall) chk("stall_rd_adr_en", rd_adr_en, 0);
            if (done) begin
                chk("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("switch_banks_count", m_sw, e.sw);
                    chk("wr_en_count", m_wr, e.wr);
                    chk("rd_adr_en_count", m_rd, e.rd);
                    chk("busy_cycles", m_cyc, e.cyc);
                    chk("busy_at_done", busy, 0);
                end
                m_sw = 0; m_wr = 0; m_rd = 0; m_cyc = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int n, input int w, input int r);
        config_en   = 1'b1;
        config_data = {CW'(n), CW'(w), CW'(r)};
        step();
        config_en   = 1'b0;
    endtask

    task automatic expect_run(input int sw, input int wr, input int rd, input int cyc);
        exp_t x;
        x.sw = sw; x.wr = wr; x.rd = rd; x.cyc = cyc;
        exp_q.push_back(x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        if (!done) chk({name, "_done_timeout"}, 0, 1);
        step();
    endtask

    task automatic wait_swap(input string name, input int budget);
        int k = 0;
        while (!switch_banks && k < budget) begin
            step();
            k++;
        end
        if (!switch_banks) chk({name, "_swap_timeout"}, 0, 1);
    endtask

    task automatic zero_run(input string name);
        expect_run(0, 0, 0, 0);
        pulse_start();
        chk({name, "_done_next"}, done, 1);
        chk({name, "_busy"}, busy, 0);
        step();
        chk({name, "_done_once"}, done, 0);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    task automatic check_all_low(input string name);
        chk({name, "_in_rdy"}, in_rdy, 0);
        chk({name, "_wr_en"}, wr_en, 0);
        chk({name, "_rd_adr_en"}, rd_adr_en, 0);
        chk({name, "_switch_banks"}, switch_banks, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        check_all_low("reset");
        rst_n = 1'b1;
        step();

        // three tiles, free-flowing streams
        in_vld = 1'b1;
        cfg(3, 4, 6);
        expect_run(4, 12, 18, 30);
        pulse_start();
        wait_done("run3x4x6", 200);

        // single tile: FILL, SWAP, DRAIN, SWAP
        cfg(1, 2, 3);
        expect_run(2, 2, 3, 9);
        pulse_start();
        wait_done("run1x2x3", 100);

        // read stall for 5 cycles at the start of STEADY
        cfg(2, 4, 6);
        expect_run(3, 8, 12, 27);
        pulse_start();
        wait_swap("stall", 50);
        step();
        rd_stall = 1'b1;
        repeat (5) step();
        rd_stall = 1'b0;
        wait_done("stall", 100);

        // write stream at 50% in STEADY, short read side
        cfg(2, 8, 2);
        expect_run(3, 16, 4, 31);
        pulse_start();
        wait_swap("toggle", 50);
        step();
        in_vld = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            in_vld = ~in_vld;
        end
        in_vld = 1'b1;
        wait_done("toggle", 100);

        // zero tiles
        cfg(0, 4, 4);
        zero_run("zero_tiles");

        // reset mid-STEADY; start/config_en during reset must be ignored
        cfg(3, 4, 6);
        pulse_start();
        wait_swap("midreset", 50);
        repeat (3) step();
        rst_n       = 1'b0;
        start       = 1'b1;
        config_en   = 1'b1;
        config_data = {CW'(5), CW'(1), CW'(1)};
        step();
        rst_n     = 1'b1;
        start     = 1'b0;
        config_en = 1'b0;
        check_all_low("after_reset");
        step();
        zero_run("cleared_config");

        cfg(2, 3, 5);
        expect_run(3, 6, 10, 19);
        pulse_start();
        wait_done("rerun2x3x5", 100);

        repeat (3) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
